// File: rtl/cordic_pkg.sv
// Shared widths, operand field offsets and the tag carried alongside the CORDIC pipe.
package cordic_pkg;
    localparam int W   = 16;
    localparam int IW  = 10;
    localparam int OPW = 4 * W + IW;

    localparam int IDX_LSB = 0;
    localparam int YR_LSB  = IW;
    localparam int XR_LSB  = IW + W;
    localparam int YM_LSB  = IW + 2 * W;
    localparam int XM_LSB  = IW + 3 * W;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    function automatic logic [OPW-1:0] pack_ops(input logic [W-1:0]  xm,
                                                input logic [W-1:0]  ym,
                                                input logic [W-1:0]  xr,
                                                input logic [W-1:0]  yr,
                                                input logic [IW-1:0] idx);
        logic [OPW-1:0] v;
        v = '0;
        v[XM_LSB +: W]   = xm;
        v[YM_LSB +: W]   = ym;
        v[XR_LSB +: W]   = xr;
        v[YR_LSB +: W]   = yr;
        v[IDX_LSB +: IW] = idx;
        return v;
    endfunction
endpackage

// File: rtl/cordic_rsp_fifo.sv
// Response FIFO: write visible on o_rd_data/!o_empty the cycle after, pop on empty ignored,
// write+pop on a full FIFO accepted together.
module cordic_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_rd   = i_rd & ~o_empty;
    assign w_do_wr   = i_wr & (~o_full | w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
        end
    end
endmodule

// File: rtl/cordic_pipe_sched.sv
// Two-requester round-robin, credit-based scheduler in front of a fixed-latency CORDIC pipe.
// Handshake to rsp_valid is LAT+2 cycles; a requester stalls only when its credits are exhausted.
module cordic_pipe_sched
    import cordic_pkg::*;
#(
    parameter int LAT     = 8,
    parameter int CREDITS = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [1:0]     i_req_valid,
    output logic [1:0]     o_req_ready,
    input  logic [OPW-1:0] i_req_data0,
    input  logic [OPW-1:0] i_req_data1,
    output logic           o_pipe_wen,
    output logic [OPW-1:0] o_pipe_data,
    input  logic           i_pipe_wen_out,
    input  logic [OPW-1:0] i_pipe_res,
    output logic [1:0]     o_rsp_valid,
    input  logic [1:0]     i_rsp_ready,
    output logic [OPW-1:0] o_rsp_data0,
    output logic [OPW-1:0] o_rsp_data1,
    output logic           o_busy,
    output logic           o_err_orphan,
    output logic           o_err_missing
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]  r_credit [2];
    logic           r_last;
    logic           r_pipe_wen;
    logic [OPW-1:0] r_pipe_data;
    tag_t           r_tag [LAT+1];
    logic           r_err_orphan;
    logic           r_err_missing;

    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic [1:0] w_pop;
    logic [1:0] w_ret;
    logic [1:0] w_fifo_wr;
    logic [1:0] w_empty;
    logic [1:0] w_full;
    tag_t       w_tail;
    logic       w_busy;

    assign w_tail = r_tag[LAT];

    for (genvar g = 0; g < 2; g++) begin : g_req
        assign w_elig[g]    = i_req_valid[g] & (r_credit[g] != '0) & ~i_reset;
        assign w_pop[g]     = i_rsp_ready[g] & ~w_empty[g];
        // Credits make a full-FIFO write impossible; the gate keeps a broken pipe from corrupting it.
        assign w_fifo_wr[g] = w_tail.valid & i_pipe_wen_out & (w_tail.id == 1'(g))
                              & (~w_full[g] | w_pop[g]);
        assign w_ret[g]     = w_tail.valid & ~i_pipe_wen_out & (w_tail.id == 1'(g));
    end

    // r_last names the requester granted most recently; the other one wins a tie.
    always_comb begin
        w_grant = w_elig;
        if (&w_elig) w_grant = r_last ? 2'b01 : 2'b10;
    end

    always_comb begin
        w_busy = r_pipe_wen;
        for (int k = 0; k <= LAT; k++) w_busy = w_busy | r_tag[k].valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2; i++) r_credit[i] <= CW'(CREDITS);
        end else begin
            for (int i = 0; i < 2; i++)
                r_credit[i] <= r_credit[i] + CW'(w_pop[i]) + CW'(w_ret[i]) - CW'(w_grant[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipe_wen  <= 1'b0;
            r_pipe_data <= '0;
            r_last      <= 1'b1;
        end else begin
            r_pipe_wen <= |w_grant;
            if (|w_grant) begin
                r_pipe_data <= w_grant[1] ? i_req_data1 : i_req_data0;
                r_last      <= w_grant[1];
            end
        end
    end

    // Stage 0 loads with the issue register, so stage LAT lines up with pipe_wen_out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= tag_t'{valid: |w_grant, id: w_grant[1]};
            for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_orphan  <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            if (w_tail.valid & ~i_pipe_wen_out) r_err_missing <= 1'b1;
            if (~w_tail.valid & i_pipe_wen_out) r_err_orphan  <= 1'b1;
        end
    end

    cordic_rsp_fifo #(.DEPTH(CREDITS), .WIDTH(OPW)) u_fifo0 (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (w_fifo_wr[0]),
        .i_wr_data (i_pipe_res),
        .i_rd      (i_rsp_ready[0]),
        .o_rd_data (o_rsp_data0),
        .o_empty   (w_empty[0]),
        .o_full    (w_full[0])
    );

    cordic_rsp_fifo #(.DEPTH(CREDITS), .WIDTH(OPW)) u_fifo1 (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (w_fifo_wr[1]),
        .i_wr_data (i_pipe_res),
        .i_rd      (i_rsp_ready[1]),
        .o_rd_data (o_rsp_data1),
        .o_empty   (w_empty[1]),
        .o_full    (w_full[1])
    );

    assign o_req_ready   = w_grant;
    assign o_pipe_wen    = r_pipe_wen;
    assign o_pipe_data   = r_pipe_data;
    assign o_rsp_valid   = ~w_empty;
    assign o_busy        = w_busy;
    assign o_err_orphan  = r_err_orphan;
    assign o_err_missing = r_err_missing;
endmodule

// File: tb/tb_cordic_pipe_sched.sv
// Bench for cordic_pipe_sched: a delay-line CORDIC pipe plus an operation-level reference model.
module tb_cordic_pipe_sched;
    import cordic_pkg::*;

    localparam int LAT     = 8;
    localparam int CREDITS = 4;
    localparam int HN      = 64;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1;
    logic [1:0]     i_req_valid = '0;
    logic [OPW-1:0] i_req_data0 = '0;
    logic [OPW-1:0] i_req_data1 = '0;
    logic           i_pipe_wen_out = 1'b0;
    logic [OPW-1:0] i_pipe_res = '0;
    logic [1:0]     i_rsp_ready = '0;
    logic [1:0]     o_req_ready;
    logic           o_pipe_wen;
    logic [OPW-1:0] o_pipe_data;
    logic [1:0]     o_rsp_valid;
    logic [OPW-1:0] o_rsp_data0;
    logic [OPW-1:0] o_rsp_data1;
    logic           o_busy;
    logic           o_err_orphan;
    logic           o_err_missing;

    always #5 clk = ~clk;

    cordic_pipe_sched #(.LAT(LAT), .CREDITS(CREDITS)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_data0    (i_req_data0),
        .i_req_data1    (i_req_data1),
        .o_pipe_wen     (o_pipe_wen),
        .o_pipe_data    (o_pipe_data),
        .i_pipe_wen_out (i_pipe_wen_out),
        .i_pipe_res     (i_pipe_res),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_data0    (o_rsp_data0),
        .o_rsp_data1    (o_rsp_data1),
        .o_busy         (o_busy),
        .o_err_orphan   (o_err_orphan),
        .o_err_missing  (o_err_missing)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_gnt [2];

    logic           drv_rst;
    logic [1:0]     drv_valid;
    logic [1:0]     drv_rdy;
    logic [OPW-1:0] drv_d0;
    logic [OPW-1:0] drv_d1;
    bit             drop_req;

    logic           hist_wen [HN];
    logic [OPW-1:0] hist_dat [HN];
    logic           env_wen;

    typedef struct {
        int             id;
        logic [OPW-1:0] d;
        int             g;
    } op_t;

    op_t            fl[$];
    logic [OPW-1:0] mq0[$];
    logic [OPW-1:0] mq1[$];
    int             m_cred [2];
    int             m_last;
    logic           m_wen;
    logic [OPW-1:0] m_dat;
    logic           m_orph;
    logic           m_miss;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [OPW-1:0] rnd_op();
        return pack_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 10'($urandom));
    endfunction

    task automatic model_reset();
        m_cred[0] = CREDITS;
        m_cred[1] = CREDITS;
        m_last    = 1;
        m_wen     = 1'b0;
        m_dat     = '0;
        m_orph    = 1'b0;
        m_miss    = 1'b0;
        fl.delete();
        mq0.delete();
        mq1.delete();
    endtask

    // One clock: drive inputs after the edge, check everything at the falling edge, advance the model.
    task automatic step();
        int   gi;
        logic e0, e1;
        op_t  op;
        @(posedge clk);
        #1;
        i_reset     = drv_rst;
        i_req_valid = drv_valid;
        i_req_data0 = drv_d0;
        i_req_data1 = drv_d1;
        i_rsp_ready = drv_rdy;
        env_wen     = 1'b0;
        i_pipe_res  = '0;
        if (cyc >= LAT) begin
            env_wen    = hist_wen[(cyc - LAT) % HN];
            i_pipe_res = hist_dat[(cyc - LAT) % HN];
        end
        if (env_wen && drop_req) begin
            env_wen  = 1'b0;
            drop_req = 1'b0;
        end
        i_pipe_wen_out = env_wen;
        @(negedge clk);
        hist_wen[cyc % HN] = o_pipe_wen;
        hist_dat[cyc % HN] = o_pipe_data;

        e0 = drv_valid[0] && (m_cred[0] > 0) && !drv_rst;
        e1 = drv_valid[1] && (m_cred[1] > 0) && !drv_rst;
        gi = -1;
        if (e0 && e1) gi = (m_last == 1) ? 0 : 1;
        else if (e0)  gi = 0;
        else if (e1)  gi = 1;

        chk("req_ready", o_req_ready, (gi < 0) ? 0 : (1 << gi));
        chk("pipe_wen", o_pipe_wen, m_wen);
        chk("pipe_data", o_pipe_data, m_dat);
        chk("rsp_valid", o_rsp_valid, {mq1.size() > 0, mq0.size() > 0});
        if (mq0.size() > 0) chk("rsp_data0", o_rsp_data0, mq0[0]);
        if (mq1.size() > 0) chk("rsp_data1", o_rsp_data1, mq1[0]);
        chk("busy", o_busy, fl.size() > 0);
        chk("err_orphan", o_err_orphan, m_orph);
        chk("err_missing", o_err_missing, m_miss);
        for (int i = 0; i < 2; i++)
            if (o_req_ready[i] && i_req_valid[i]) n_gnt[i]++;

        if (drv_rst) begin
            model_reset();
        end else begin
            if (drv_rdy[0] && mq0.size() > 0) begin mq0.delete(0); m_cred[0]++; end
            if (drv_rdy[1] && mq1.size() > 0) begin mq1.delete(0); m_cred[1]++; end
            if (fl.size() > 0 && fl[0].g + LAT + 1 == cyc) begin
                op = fl.pop_front();
                if (env_wen) begin
                    if (op.id == 0) mq0.push_back(op.d);
                    else            mq1.push_back(op.d);
                end else begin
                    m_miss = 1'b1;
                    m_cred[op.id]++;
                end
            end else if (env_wen) begin
                m_orph = 1'b1;
            end
            if (gi >= 0) begin
                m_cred[gi]--;
                m_last = gi;
                m_wen  = 1'b1;
                m_dat  = (gi == 1) ? drv_d1 : drv_d0;
                op.id  = gi;
                op.d   = m_dat;
                op.g   = cyc;
                fl.push_back(op);
            end else begin
                m_wen = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        drv_valid = 2'b00;
        drv_rdy   = 2'b11;
        repeat (n) step();
    endtask

    initial begin
        int             t0;
        int             first_rsp;
        int             g0;
        int             g1;
        logic [OPW-1:0] first_dat;
        logic [OPW-1:0] t1_op;

        drv_rst = 1'b1; drv_valid = '0; drv_rdy = '0; drv_d0 = '0; drv_d1 = '0; drop_req = 1'b0;
        n_gnt[0] = 0; n_gnt[1] = 0;
        for (int i = 0; i < HN; i++) begin hist_wen[i] = 1'b0; hist_dat[i] = '0; end
        model_reset();
        repeat (3) step();
        drv_rst = 1'b0;

        // single request: issue, latency and data of the response
        t1_op     = pack_ops(16'h1000, 16'h0000, 16'h0000, 16'h0000, 10'h155);
        drv_d0    = t1_op;
        drv_valid = 2'b01;
        t0 = cyc;
        step();
        drv_valid = 2'b00;
        first_rsp = -1;
        first_dat = '0;
        for (int k = 0; k < LAT + 6; k++) begin
            step();
            if (first_rsp < 0 && o_rsp_valid[0]) begin
                first_rsp = cyc - 1;
                first_dat = o_rsp_data0;
            end
        end
        chk("t1_latency", first_rsp, t0 + LAT + 2);
        chk("t1_data", first_dat, t1_op);
        idle(2);

        // both requesters hammering: strict alternation with no idle issue slot at first
        g0 = n_gnt[0]; g1 = n_gnt[1];
        drv_valid = 2'b11;
        drv_rdy   = 2'b11;
        for (int k = 0; k < 40; k++) begin
            drv_d0 = rnd_op();
            drv_d1 = rnd_op();
            step();
            if (k == 7) begin
                chk("t2_issues8", (n_gnt[0] - g0) + (n_gnt[1] - g1), 8);
                chk("t2_share0", n_gnt[0] - g0, 4);
            end
        end
        idle(LAT + 8);

        // credit exhaustion on requester 0, then a single pop releases exactly one grant
        g0 = n_gnt[0];
        drv_valid = 2'b01;
        drv_rdy   = 2'b00;
        for (int k = 0; k < LAT + 6; k++) begin
            drv_d0 = rnd_op();
            step();
        end
        chk("t3_grants", n_gnt[0] - g0, CREDITS);
        chk("t3_blocked", o_req_ready[0], 1'b0);
        g0 = n_gnt[0];
        drv_rdy = 2'b01;
        step();
        drv_rdy = 2'b00;
        repeat (5) step();
        chk("t3_one_more", n_gnt[0] - g0, 1);
        idle(LAT + 10);

        // random traffic and backpressure
        for (int k = 0; k < 1000; k++) begin
            drv_valid = 2'($urandom);
            drv_rdy   = 2'($urandom);
            drv_d0    = rnd_op();
            drv_d1    = rnd_op();
            step();
        end
        idle(LAT + 10);

        // reset with three operations in flight; the external pipe still delivers them
        drv_valid = 2'b01;
        repeat (3) begin drv_d0 = rnd_op(); step(); end
        drv_valid = 2'b00;
        repeat (2) step();
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        step();
        chk("t5_pipe_wen", o_pipe_wen, 1'b0);
        chk("t5_busy", o_busy, 1'b0);
        idle(LAT + 4);
        chk("t5_orphan", o_err_orphan, 1'b1);

        // dropped result: sticky err_missing, credit comes back, requester keeps going
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        idle(2);
        chk("t6_cleared", o_err_orphan, 1'b0);
        drop_req  = 1'b1;
        drv_valid = 2'b10;
        repeat (2) begin drv_d1 = rnd_op(); step(); end
        idle(LAT + 4);
        chk("t6_missing", o_err_missing, 1'b1);
        idle(3);
        chk("t6_sticky", o_err_missing, 1'b1);
        g1 = n_gnt[1];
        drv_valid = 2'b10;
        drv_rdy   = 2'b00;
        for (int k = 0; k < LAT + 6; k++) begin
            drv_d1 = rnd_op();
            step();
        end
        chk("t6_credits", n_gnt[1] - g1, CREDITS);
        idle(LAT + 6);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
